// File: rtl/mux_pkg.sv
// Shared constants and state encoding for the 4:1 mux scan sequencer.
package mux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } scan_state_t;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the scan controller and its mux + consumer.
interface mux_scan_ctrl_if;
  logic                         Start;
  logic                         Cont;
  logic                         Y;
  logic                         Ready;
  logic [mux_pkg::SEL_W-1:0]    Sel;
  logic [mux_pkg::NUM_CH-1:0]   Data;
  logic                         Valid;
  logic                         Busy;

  modport master (
    input  Start, Cont, Y, Ready,
    output Sel, Data, Valid, Busy
  );

  modport slave (
    output Start, Cont, Y, Ready,
    input  Sel, Data, Valid, Busy
  );
endinterface

// File: rtl/mux_settle_timer.sv
// Settle counter: counts while enabled and flags the last cycle of each hold,
// then wraps to zero so the next channel gets a full SETTLE window.
module mux_settle_timer
  import mux_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || done) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all channels, samples Y at the end of each
// settle window and presents the assembled word on a valid/ready handshake.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  mux_scan_ctrl_if.master  bus
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE must be in 1..15");
  end

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  scan_state_t        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_CH-1:0]  cap_q, cap_d;
  logic [NUM_CH-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               tmr_clr, tmr_en, tmr_done;

  assign tmr_en = (state_q == ST_SETTLE);

  mux_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .done (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cap_d   = cap_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    tmr_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          state_d = ST_SETTLE;
          sel_d   = '0;
          busy_d  = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          cap_d[sel_q] = bus.Y;
          if (sel_q == LAST_SEL) begin
            // Last channel goes straight into Data; cap only holds 0..2 here.
            data_d  = {bus.Y, cap_q[NUM_CH-2:0]};
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.Ready) begin
          valid_d = 1'b0;
          sel_d   = '0;
          if (bus.Cont) begin
            state_d = ST_SETTLE;
            tmr_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Sel   = sel_q;
  assign bus.Data  = data_q;
  assign bus.Valid = valid_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench: SETTLE=2 instance for scan/backpressure/continuous/reset,
// SETTLE=1 instance for the minimum-settle case.
module tb_mux_scan_ctrl;

  logic Clk;
  logic Rst;
  logic [3:0] mux0_i, mux1_i;
  int n_tests, n_fail;

  mux_scan_ctrl_if b0 ();
  mux_scan_ctrl_if b1 ();

  assign b0.Y = mux0_i[b0.Sel];
  assign b1.Y = mux1_i[b1.Sel];

  mux_scan_ctrl #(.SETTLE(2)) u_dut0 (.Clk(Clk), .Rst(Rst), .bus(b0));
  mux_scan_ctrl #(.SETTLE(1)) u_dut1 (.Clk(Clk), .Rst(Rst), .bus(b1));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic seen;
    n_tests = 0;
    n_fail  = 0;
    Rst = 1'b1;
    mux0_i = 4'b0000;
    mux1_i = 4'b0000;
    b0.Start = 0; b0.Cont = 0; b0.Ready = 0;
    b1.Start = 0; b1.Cont = 0; b1.Ready = 0;
    tick();
    tick();
    Rst = 1'b0;

    chk("rst sel",   b0.Sel,   0);
    chk("rst data",  b0.Data,  0);
    chk("rst valid", b0.Valid, 0);
    chk("rst busy",  b0.Busy,  0);

    // 1: basic scan
    mux0_i = 4'b1010;
    b0.Ready = 1;
    b0.Start = 1;
    tick();
    b0.Start = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1 sel@%0d", k), b0.Sel, k / 2);
      chk($sformatf("t1 valid@%0d", k), b0.Valid, 0);
      chk($sformatf("t1 busy@%0d", k), b0.Busy, 1);
      tick();
    end
    chk("t1 valid",  b0.Valid, 1);
    chk("t1 data",   b0.Data,  4'b1010);
    chk("t1 sel3",   b0.Sel,   3);
    tick();
    chk("t1 valid drop", b0.Valid, 0);
    chk("t1 idle busy",  b0.Busy,  0);
    chk("t1 idle sel",   b0.Sel,   0);
    chk("t1 data kept",  b0.Data,  4'b1010);

    // 2: backpressure, Start during hold ignored
    b0.Ready = 0;
    b0.Start = 1;
    tick();
    b0.Start = 0;
    repeat (8) tick();
    chk("t2 valid", b0.Valid, 1);
    chk("t2 data",  b0.Data,  4'b1010);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) b0.Start = 1;
      if (k == 2) b0.Start = 0;
      tick();
      chk($sformatf("t2 hold valid@%0d", k), b0.Valid, 1);
      chk($sformatf("t2 hold data@%0d", k),  b0.Data,  4'b1010);
      chk($sformatf("t2 hold busy@%0d", k),  b0.Busy,  1);
    end
    b0.Ready = 1;
    tick();
    chk("t2 valid drop", b0.Valid, 0);
    chk("t2 busy drop",  b0.Busy,  0);
    tick();
    chk("t2 start not queued", b0.Busy, 0);

    // 3: continuous mode
    b0.Cont = 1;
    b0.Ready = 1;
    mux0_i = 4'b1010;
    b0.Start = 1;
    tick();
    b0.Start = 0;
    repeat (8) tick();
    chk("t3 valid1", b0.Valid, 1);
    chk("t3 data1",  b0.Data,  4'b1010);
    mux0_i = 4'b0101;
    tick();
    chk("t3 restart sel",   b0.Sel,   0);
    chk("t3 restart valid", b0.Valid, 0);
    chk("t3 restart busy",  b0.Busy,  1);
    repeat (7) tick();
    chk("t3 no early valid", b0.Valid, 0);
    tick();
    chk("t3 valid2", b0.Valid, 1);
    chk("t3 data2",  b0.Data,  4'b0101);
    b0.Cont = 0;
    tick();
    chk("t3 end busy",  b0.Busy,  0);
    chk("t3 end valid", b0.Valid, 0);

    // 4: reset mid-scan
    mux0_i = 4'b1111;
    b0.Start = 1;
    tick();
    b0.Start = 0;
    tick();
    tick();
    Rst = 1;
    tick();
    Rst = 0;
    chk("t4 sel",   b0.Sel,   0);
    chk("t4 valid", b0.Valid, 0);
    chk("t4 busy",  b0.Busy,  0);
    chk("t4 data",  b0.Data,  0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (b0.Valid !== 1'b0 || b0.Busy !== 1'b0) seen = 1'b1;
    end
    chk("t4 quiet after reset", seen, 0);

    // 5: minimum settle on the SETTLE=1 instance
    mux1_i = 4'b0110;
    b1.Ready = 1;
    b1.Start = 1;
    tick();
    b1.Start = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5 sel@%0d", k), b1.Sel, k);
      chk($sformatf("t5 valid@%0d", k), b1.Valid, 0);
      tick();
    end
    chk("t5 valid", b1.Valid, 1);
    chk("t5 data",  b1.Data,  4'b0110);
    tick();
    chk("t5 valid drop", b1.Valid, 0);
    chk("t5 busy drop",  b1.Busy,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
